// File: rtl/tx_arbiter.sv
// Purpose : round-robin arbiter feeding one shared TX serializer from Nreq byte requesters.
// Latency : GNT and captured TX_DIN one cycle after an IDLE request, TX_OE one cycle later,
//           then one full frame (Tframe cycles) before the next grant can be issued.
// Backpressure: requests are levels; they are ignored outside IDLE and simply wait their turn.
//
// Ports
//   CLK, RSTN      clock, asynchronous active-low reset
//   REQ[Nreq]      per-requester byte-pending level
//   DIN[Nreq*Wdata] requester bytes, slice i belongs to requester i
//   GNT[Nreq]      one-hot grant pulse, the granted slice is captured on the same edge
//   TX_DIN, TX_OE  byte and one-cycle load strobe to the serializer
//   TX_RST         active-high serializer reset, held through RSTN and one edge after
//   BUSY           high whenever the FSM is not IDLE
module tx_arbiter #(
    parameter int Nreq  = 4,
    parameter int Wdata = 8,
    parameter int Wstop = 1,
    parameter int Bauds = 115200,
    parameter int Fclk  = 12000000
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic [Nreq-1:0]        REQ,
    input  logic [Nreq*Wdata-1:0]  DIN,
    output logic [Nreq-1:0]        GNT,
    output logic [Wdata-1:0]       TX_DIN,
    output logic                   TX_OE,
    output logic                   TX_RST,
    output logic                   BUSY
);

    localparam int Nticks = Fclk / Bauds;
    localparam int Wframe = 1 + Wdata + Wstop;
    localparam int Tframe = Wframe * (Nticks + 1) + 1;
    localparam int CW     = $clog2(Tframe);
    localparam int PW     = (Nreq > 1) ? $clog2(Nreq) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [Nreq-1:0]   gnt_q;
    logic [Wdata-1:0]  tx_din_q;
    logic              tx_oe_q;
    logic              tx_rst_q;

    // Unpack the flat data bus so the winner can index it directly.
    logic [Wdata-1:0]  din_a [Nreq];
    for (genvar g = 0; g < Nreq; g++) begin : g_unpack
        assign din_a[g] = DIN[g*Wdata +: Wdata];
    end

    // Round-robin search: first set REQ bit at or above the pointer, wrapping.
    logic              found;
    logic [PW-1:0]     win;
    logic [PW-1:0]     cand;
    logic [PW-1:0]     ptr_d;
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < Nreq; k++) begin
            cand = PW'((int'(ptr_q) + k) % Nreq);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        ptr_d = PW'((int'(win) + 1) % Nreq);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            tx_din_q <= '0;
            tx_oe_q  <= 1'b0;
            tx_rst_q <= 1'b1;
        end else begin
            gnt_q    <= '0;
            tx_oe_q  <= 1'b0;
            tx_rst_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The edge that drops TX_RST is spent releasing the serializer.
                    if (!tx_rst_q && found) begin
                        gnt_q    <= Nreq'(1) << win;
                        tx_din_q <= din_a[win];
                        ptr_q    <= ptr_d;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    tx_oe_q <= 1'b1;
                    cnt_q   <= CW'(Tframe - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign GNT    = gnt_q;
    assign TX_DIN = tx_din_q;
    assign TX_OE  = tx_oe_q;
    assign TX_RST = tx_rst_q;
    assign BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// Purpose : directed self-checking bench for tx_arbiter at Nreq=4, Wdata=8, Fclk=16, Bauds=4.
// Latency : grant frames repeat every 53 cycles (Tframe = 51).
// Backpressure: none; requests are driven as levels by the sequence below.
module tb_tx_arbiter;

    localparam int NR = 4;
    localparam int WD = 8;
    localparam int GAP = 53;

    logic            CLK = 1'b0;
    logic            RSTN;
    logic [NR-1:0]   REQ;
    logic [NR*WD-1:0] DIN;
    logic [NR-1:0]   GNT;
    logic [WD-1:0]   TX_DIN;
    logic            TX_OE;
    logic            TX_RST;
    logic            BUSY;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int last_g = 0;

    tx_arbiter #(.Nreq(NR), .Wdata(WD), .Wstop(1), .Bauds(4), .Fclk(16)) dut (
        .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .DIN(DIN), .GNT(GNT),
        .TX_DIN(TX_DIN), .TX_OE(TX_OE), .TX_RST(TX_RST), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Wait (bounded) for the next grant, check its value and distance from the previous one.
    task automatic wait_gnt(input string tag, input logic [NR-1:0] exp, input int exp_gap);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (GNT == '0 && n < 200);
        chk({tag, "_gnt"}, 32'(GNT), 32'(exp));
        if (exp_gap > 0) chk({tag, "_gap"}, 32'(cyc - last_g), 32'(exp_gap));
        last_g = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 200) begin
            step();
            n++;
        end
        chk("idle_reached", 32'(BUSY), 32'd0);
    endtask

    initial begin
        logic stable;
        RSTN = 1'b0;
        REQ  = '0;
        DIN  = {8'h44, 8'hA5, 8'h22, 8'h11};

        // Reset state
        step(); step();
        chk("rst_busy",   32'(BUSY),   32'd0);
        chk("rst_gnt",    32'(GNT),    32'd0);
        chk("rst_oe",     32'(TX_OE),  32'd0);
        chk("rst_txdin",  32'(TX_DIN), 32'd0);
        chk("rst_txrst",  32'(TX_RST), 32'd1);

        // Single request to requester 2; release reset with the request already up.
        REQ  = 4'b0100;
        RSTN = 1'b1;
        step();
        chk("rel_txrst",  32'(TX_RST), 32'd0);
        chk("rel_nogrant", 32'(GNT),   32'd0);
        step();
        chk("single_gnt", 32'(GNT),    32'b0100);
        chk("single_din", 32'(TX_DIN), 32'hA5);
        chk("single_busy", 32'(BUSY),  32'd1);
        chk("single_oe0", 32'(TX_OE),  32'd0);
        last_g = cyc;
        REQ = '0;
        step();
        chk("single_oe",  32'(TX_OE),  32'd1);
        chk("single_oedin", 32'(TX_DIN), 32'hA5);
        chk("single_gnt_pulse", 32'(GNT), 32'd0);
        step();
        chk("single_oe_pulse", 32'(TX_OE), 32'd0);
        stable = 1'b1;
        for (int i = 0; i < 49; i++) begin
            step();
            if (TX_DIN !== 8'hA5 || TX_OE !== 1'b0) stable = 1'b0;
        end
        chk("single_stable", 32'(stable), 32'd1);
        chk("single_busy_last", 32'(BUSY), 32'd1);
        step();
        chk("single_busy_low", 32'(BUSY), 32'd0);

        // Skip and wrap: pointer is now 3.
        REQ = 4'b0010;
        wait_gnt("skip", 4'b0010, GAP);
        chk("skip_din", 32'(TX_DIN), 32'h22);
        REQ = 4'b1010;
        wait_gnt("wrap", 4'b1000, GAP);
        chk("wrap_din", 32'(TX_DIN), 32'h44);
        REQ = '0;
        wait_idle();

        // Mid-frame reset, 10 cycles into WAIT.
        REQ = 4'b0001;
        wait_gnt("mid", 4'b0001, 0);
        REQ = '0;
        for (int i = 0; i < 11; i++) step();
        chk("mid_in_wait", 32'(BUSY), 32'd1);
        RSTN = 1'b0;
        #1;
        chk("mid_busy",  32'(BUSY),   32'd0);
        chk("mid_oe",    32'(TX_OE),  32'd0);
        chk("mid_txrst", 32'(TX_RST), 32'd1);
        chk("mid_txdin", 32'(TX_DIN), 32'd0);
        step();
        REQ  = 4'b0001;
        RSTN = 1'b1;
        step();
        chk("mid_rel_nogrant", 32'(GNT), 32'd0);
        step();
        chk("mid_regrant", 32'(GNT), 32'b0001);
        last_g = cyc;
        REQ = '0;

        // Late request: requester 1 rises during requester 0's WAIT.
        for (int i = 0; i < 12; i++) step();
        REQ = 4'b0010;
        wait_gnt("late", 4'b0010, GAP);
        REQ = '0;
        wait_idle();

        // All requesting from reset: strict rotation 0,1,2,3,0.
        RSTN = 1'b0;
        REQ  = 4'b1111;
        step();
        RSTN = 1'b1;
        step();
        wait_gnt("all0", 4'b0001, 0);
        wait_gnt("all1", 4'b0010, GAP);
        wait_gnt("all2", 4'b0100, GAP);
        chk("all2_din", 32'(TX_DIN), 32'hA5);
        wait_gnt("all3", 4'b1000, GAP);
        wait_gnt("all4", 4'b0001, GAP);
        chk("all4_din", 32'(TX_DIN), 32'h11);
        REQ = '0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
